// File: rtl/fetch_ctrl_pkg.sv
// ============================================================================
// Module   : fetch_ctrl_pkg
// Purpose  : Shared widths, types and state encoding for the YASAC
//            instruction-fetch sequencer (fetch_ctrl and its return stack).
// Contents : ADDR_W / CODE_W widths, addr_t / code_t types, state_t FSM
//            encoding (1 bit), addr_inc() modulo-256 increment helper.
// Options  : none (FETCH_RSTACK_EN is consumed by fetch_ctrl).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_ctrl_pkg;

  localparam int ADDR_W = 8;
  localparam int CODE_W = 16;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [CODE_W-1:0] code_t;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  // Fetch addresses wrap from 8'hFF to 8'h00.
  function automatic addr_t addr_inc(input addr_t a);
    return a + addr_t'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_ctrl_if.sv
// ============================================================================
// Module   : fetch_ctrl_if
// Purpose  : Bundle of the code-memory, decode handshake and control signals
//            of the fetch sequencer.
// Modports : master - the fetch sequencer (drives address, ir, ir_valid, pc,
//                     halted, stk_err)
//            slave  - the surrounding system (code memory + decode/control)
// Signals  : address/data (code memory), ir/ir_valid/ir_ready/pc (decode),
//            branch/branch_addr/call/ret/halt/resume (control in),
//            halted/stk_err (status out)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;

  addr_t address;
  code_t data;
  code_t ir;
  logic  ir_valid;
  logic  ir_ready;
  addr_t pc;
  logic  branch;
  addr_t branch_addr;
  logic  call;
  logic  ret;
  logic  halt;
  logic  resume;
  logic  halted;
  logic  stk_err;

  modport master (
    output address, ir, ir_valid, pc, halted, stk_err,
    input  data, ir_ready, branch, branch_addr, call, ret, halt, resume
  );

  modport slave (
    input  address, ir, ir_valid, pc, halted, stk_err,
    output data, ir_ready, branch, branch_addr, call, ret, halt, resume
  );

endinterface

`default_nettype wire

// File: rtl/fetch_ret_stack.sv
// ============================================================================
// Module   : fetch_ret_stack
// Purpose  : Circular LIFO of return addresses. A push onto a full stack
//            overwrites the oldest entry; a pop from an empty stack is
//            ignored. Both events set the sticky err flag.
// Ports    : clk, rst_n (sync, active-low), push, pop, push_data,
//            top (most recent entry), empty, err (sticky)
// Params   : DEPTH - entries, power of 2 in 2..16
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_ret_stack
  import fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  logic  pop,
  input  addr_t push_data,
  output addr_t top,
  output logic  empty,
  output logic  err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  addr_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;   // next slot to write; top sits just below
  logic [CNT_W-1:0] count;    // live entries, saturates at DEPTH
  logic             err_q;
  logic             full;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign top   = mem[wr_ptr - PTR_W'(1)];
  assign err   = err_q;

  // Storage needs no reset: count gates every read that matters.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      count  <= '0;
      err_q  <= 1'b0;
    end else if (push) begin
      // Pointer keeps wrapping, so a full push replaces the oldest entry.
      wr_ptr <= wr_ptr + PTR_W'(1);
      if (full) begin
        err_q <= 1'b1;
      end else begin
        count <= count + CNT_W'(1);
      end
    end else if (pop) begin
      if (empty) begin
        err_q <= 1'b1;
      end else begin
        wr_ptr <= wr_ptr - PTR_W'(1);
        count  <= count - CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
// Module   : fetch_ctrl
// Purpose  : YASAC instruction-fetch sequencer. Owns the fetch PC (FPC),
//            drives the code memory address, latches the returned word into
//            IR with a valid/ready handshake towards decode, and handles
//            branch redirect, halt/resume and an optional call/return stack.
// Ports    : clk        - clock, rising edge
//            rst_n      - synchronous reset, active-low
//            bus        - fetch_ctrl_if.master (code memory, IR handshake,
//                         branch/call/ret/halt/resume, halted, stk_err)
// Params   : RESET_VECTOR - FPC value after reset
//            STACK_DEPTH  - return stack entries (only with FETCH_RSTACK_EN)
// Options  : `define FETCH_RSTACK_EN to build the hardware call/return stack;
//            without it call/ret are ignored and stk_err is tied low.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter addr_t RESET_VECTOR = 8'h00,
  parameter int    STACK_DEPTH  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_ctrl_if.master bus
);

  state_t state_q, state_d;
  addr_t  fpc_q,   fpc_d;
  addr_t  pc_q,    pc_d;
  code_t  ir_q,    ir_d;
  logic   valid_q, valid_d;

  logic   do_push;
  logic   do_pop;
  logic   ret_en;
  logic   call_en;
  logic   stk_empty;
  addr_t  stk_top;

`ifdef FETCH_RSTACK_EN
  assign ret_en  = bus.ret;
  assign call_en = bus.call;

  // Return address is the instruction after the one in IR (the call).
  fetch_ret_stack #(
    .DEPTH     (STACK_DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (do_push),
    .pop       (do_pop),
    .push_data (addr_inc(pc_q)),
    .top       (stk_top),
    .empty     (stk_empty),
    .err       (bus.stk_err)
  );
`else
  assign ret_en      = 1'b0;
  assign call_en     = 1'b0;
  assign stk_top     = '0;
  assign stk_empty   = 1'b1;
  assign bus.stk_err = 1'b0;

  logic unused_stack_sigs;
  assign unused_stack_sigs = ^{bus.call, bus.ret, do_push, do_pop, STACK_DEPTH};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      fpc_q   <= RESET_VECTOR;
      pc_q    <= '0;
      ir_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
    end
  end

  // Priority inside RUN: halt > ret > branch(/call) > load.
  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    do_push = 1'b0;
    do_pop  = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (bus.halt) begin
          state_d = ST_HALTED;
          valid_d = 1'b0;
          if (bus.branch) begin
            fpc_d = bus.branch_addr;
          end
        end else if (ret_en) begin
          // Empty stack: FPC holds but the IR is still flushed.
          do_pop  = 1'b1;
          valid_d = 1'b0;
          if (!stk_empty) begin
            fpc_d = stk_top;
          end
        end else if (bus.branch) begin
          // Redirect flushes IR even if decode is consuming it now.
          fpc_d   = bus.branch_addr;
          valid_d = 1'b0;
          do_push = call_en;
        end else if (!valid_q || bus.ir_ready) begin
          ir_d    = bus.data;
          pc_d    = fpc_q;
          valid_d = 1'b1;
          fpc_d   = addr_inc(fpc_q);
        end
      end

      ST_HALTED: begin
        if (bus.branch) begin
          fpc_d = bus.branch_addr;
        end
        if (bus.resume && !bus.halt) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign bus.address  = fpc_q;
  assign bus.ir       = ir_q;
  assign bus.ir_valid = valid_q;
  assign bus.pc       = pc_q;
  assign bus.halted   = (state_q == ST_HALTED);

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
// Module   : tb_fetch_ctrl
// Purpose  : Self-checking bench for fetch_ctrl: directed vector table,
//            hand-written call/return sequences and randomized stimulus
//            compared against a behavioural model with a code memory image.
// Options  : honours FETCH_RSTACK_EN the same way as the design.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_ctrl_if bus ();

  code_t code_mem [256];
  assign bus.data = code_mem[bus.address];

  fetch_ctrl #(
    .RESET_VECTOR (8'h00),
    .STACK_DEPTH  (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit    rst_n;
    bit    ready;
    bit    branch;
    addr_t baddr;
    bit    call;
    bit    ret;
    bit    halt;
    bit    resume;
  } in_t;

  typedef struct {
    in_t   in;
    bit    e_valid;
    addr_t e_pc;
    addr_t e_addr;
    bit    e_halted;
  } vec_t;

  // Behavioural reference state
  addr_t m_fpc, m_pc;
  code_t m_ir;
  bit    m_valid, m_halted, m_err;
  addr_t m_stack [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic in_t mk_in(bit rn, bit ready, bit br, addr_t ba, bit call, bit ret,
                                bit halt, bit resume);
    in_t s;
    s.rst_n = rn; s.ready = ready; s.branch = br; s.baddr = ba;
    s.call = call; s.ret = ret; s.halt = halt; s.resume = resume;
    return s;
  endfunction

  function automatic vec_t mk(bit rn, bit ready, bit br, addr_t ba, bit halt, bit resume,
                              bit ev, addr_t epc, addr_t eaddr, bit eh);
    vec_t v;
    v.in = mk_in(rn, ready, br, ba, 1'b0, 1'b0, halt, resume);
    v.e_valid = ev; v.e_pc = epc; v.e_addr = eaddr; v.e_halted = eh;
    return v;
  endfunction

  task automatic model_step(input in_t s);
    if (!s.rst_n) begin
      m_fpc = 8'h00; m_pc = 8'h00; m_ir = 16'h0000;
      m_valid = 0; m_halted = 0; m_err = 0;
      m_stack.delete();
    end else if (!m_halted) begin
      if (s.halt) begin
        m_halted = 1; m_valid = 0;
        if (s.branch) m_fpc = s.baddr;
      end
`ifdef FETCH_RSTACK_EN
      else if (s.ret) begin
        m_valid = 0;
        if (m_stack.size() == 0) m_err = 1;
        else m_fpc = m_stack.pop_back();
      end
`endif
      else if (s.branch) begin
`ifdef FETCH_RSTACK_EN
        if (s.call) begin
          if (m_stack.size() == DEPTH) begin
            void'(m_stack.pop_front());
            m_err = 1;
          end
          m_stack.push_back(addr_t'(m_pc + 8'd1));
        end
`endif
        m_fpc = s.baddr; m_valid = 0;
      end else if (!m_valid || s.ready) begin
        m_ir = code_mem[m_fpc]; m_pc = m_fpc; m_valid = 1;
        m_fpc = addr_t'(m_fpc + 8'd1);
      end
    end else begin
      if (s.branch) m_fpc = s.baddr;
      if (s.resume && !s.halt) m_halted = 0;
    end
  endtask

  // Apply inputs after a falling edge, let one rising edge pass, land on the next falling edge.
  task automatic cycle(input in_t s);
    rst_n           = s.rst_n;
    bus.ir_ready    = s.ready;
    bus.branch      = s.branch;
    bus.branch_addr = s.baddr;
    bus.call        = s.call;
    bus.ret         = s.ret;
    bus.halt        = s.halt;
    bus.resume      = s.resume;
    @(posedge clk);
    model_step(s);
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".address"}, 32'(bus.address),  32'(m_fpc));
    check({tag, ".ir_valid"}, 32'(bus.ir_valid), 32'(m_valid));
    check({tag, ".pc"},       32'(bus.pc),       32'(m_pc));
    check({tag, ".ir"},       32'(bus.ir),       32'(m_ir));
    check({tag, ".halted"},   32'(bus.halted),   32'(m_halted));
    check({tag, ".stk_err"},  32'(bus.stk_err),  32'(m_err));
  endtask

  vec_t tbl [$];
  in_t  ri;
  in_t  rdy;
  in_t  rst;

  initial begin
    for (int i = 0; i < 256; i++) begin
      code_mem[i] = 16'({~i[7:0], i[7:0]}) ^ 16'h1234;
    end
    rdy = mk_in(1, 1, 0, 8'h00, 0, 0, 0, 0);
    rst = mk_in(0, 0, 0, 8'h00, 0, 0, 0, 0);

    // Directed table: rst, ready, branch, baddr, halt, resume | valid, pc, address, halted
    tbl.push_back(mk(0,0,0,8'h00,0,0, 0,8'h00,8'h00,0));   // reset
    tbl.push_back(mk(1,1,0,8'h00,0,0, 1,8'h00,8'h01,0));   // first fetch
    for (int k = 1; k <= 5; k++)
      tbl.push_back(mk(1,1,0,8'h00,0,0, 1,addr_t'(k),addr_t'(k+1),0));
    for (int k = 0; k < 3; k++)                              // stall at PC=5
      tbl.push_back(mk(1,0,0,8'h00,0,0, 1,8'h05,8'h06,0));
    for (int k = 6; k <= 10; k++)
      tbl.push_back(mk(1,1,0,8'h00,0,0, 1,addr_t'(k),addr_t'(k+1),0));
    tbl.push_back(mk(1,1,1,8'h40,0,0, 0,8'h0A,8'h40,0));   // branch flushes
    tbl.push_back(mk(1,1,0,8'h00,0,0, 1,8'h40,8'h41,0));
    tbl.push_back(mk(1,1,0,8'h00,0,0, 1,8'h41,8'h42,0));
    tbl.push_back(mk(1,1,1,8'hFE,0,0, 0,8'h41,8'hFE,0));
    tbl.push_back(mk(1,1,0,8'h00,0,0, 1,8'hFE,8'hFF,0));
    tbl.push_back(mk(1,1,0,8'h00,0,0, 1,8'hFF,8'h00,0));   // wrap
    tbl.push_back(mk(1,1,0,8'h00,0,0, 1,8'h00,8'h01,0));
    tbl.push_back(mk(1,1,1,8'h14,0,0, 0,8'h00,8'h14,0));
    tbl.push_back(mk(1,1,0,8'h00,0,0, 1,8'h14,8'h15,0));
    tbl.push_back(mk(1,1,0,8'h00,1,0, 0,8'h14,8'h15,1));   // halt at PC=20
    tbl.push_back(mk(1,1,0,8'h00,0,0, 0,8'h14,8'h15,1));   // frozen
    tbl.push_back(mk(1,1,1,8'h30,0,0, 0,8'h14,8'h30,1));   // branch while halted
    tbl.push_back(mk(1,1,0,8'h00,1,1, 0,8'h14,8'h30,1));   // halt beats resume
    tbl.push_back(mk(1,1,0,8'h00,0,1, 0,8'h14,8'h30,0));   // resume
    tbl.push_back(mk(1,1,0,8'h00,0,0, 1,8'h30,8'h31,0));
    tbl.push_back(mk(1,1,0,8'h00,1,0, 0,8'h30,8'h31,1));
    tbl.push_back(mk(0,1,0,8'h00,0,0, 0,8'h00,8'h00,0));   // reset while halted
    tbl.push_back(mk(1,1,0,8'h00,0,0, 1,8'h00,8'h01,0));

    rst_n = 1'b0;
    bus.ir_ready = 0; bus.branch = 0; bus.branch_addr = '0;
    bus.call = 0; bus.ret = 0; bus.halt = 0; bus.resume = 0;
    @(negedge clk);

    foreach (tbl[i]) begin
      cycle(tbl[i].in);
      check($sformatf("tbl%0d.ir_valid", i), 32'(bus.ir_valid), 32'(tbl[i].e_valid));
      check($sformatf("tbl%0d.pc", i),       32'(bus.pc),       32'(tbl[i].e_pc));
      check($sformatf("tbl%0d.address", i),  32'(bus.address),  32'(tbl[i].e_addr));
      check($sformatf("tbl%0d.halted", i),   32'(bus.halted),   32'(tbl[i].e_halted));
      check($sformatf("tbl%0d.stk_err", i),  32'(bus.stk_err),  32'(0));
      if (tbl[i].e_valid)
        check($sformatf("tbl%0d.ir", i), 32'(bus.ir), 32'(code_mem[tbl[i].e_pc]));
      if (!tbl[i].in.rst_n)
        check($sformatf("tbl%0d.ir_reset", i), 32'(bus.ir), 32'(0));
    end

    // Call / return sequences, starting with IR holding PC=3
    cycle(rst);
    for (int k = 0; k < 4; k++) cycle(rdy);
    check("seq.pc3", 32'(bus.pc), 32'h03);
`ifdef FETCH_RSTACK_EN
    cycle(mk_in(1, 1, 1, 8'h80, 1, 0, 0, 0));
    check("call.address", 32'(bus.address), 32'h80);
    check("call.ir_valid", 32'(bus.ir_valid), 32'h0);
    cycle(rdy);
    check("call.pc", 32'(bus.pc), 32'h80);
    cycle(mk_in(1, 1, 0, 8'h00, 0, 1, 0, 0));
    check("ret.address", 32'(bus.address), 32'h04);
    check("ret.ir_valid", 32'(bus.ir_valid), 32'h0);
    cycle(rdy);
    check("ret.pc", 32'(bus.pc), 32'h04);
    check("ret.stk_err", 32'(bus.stk_err), 32'h0);
    for (int k = 0; k < 5; k++) begin
      cycle(mk_in(1, 1, 1, addr_t'(8'h90 + k), 1, 0, 0, 0));
      cycle(rdy);
      check_model($sformatf("nest%0d", k));
    end
    check("overflow.stk_err", 32'(bus.stk_err), 32'h1);
    cycle(mk_in(1, 1, 0, 8'h00, 0, 1, 0, 0));
    check("pop_newest.address", 32'(bus.address), 32'h94);
    for (int k = 0; k < 4; k++) begin
      cycle(mk_in(1, 1, 0, 8'h00, 0, 1, 0, 0));
      check_model($sformatf("unwind%0d", k));
    end
    cycle(rst);
    cycle(rdy);
    cycle(mk_in(1, 1, 0, 8'h00, 0, 1, 0, 0));
    check("ret_empty.address", 32'(bus.address), 32'h01);
    check("ret_empty.ir_valid", 32'(bus.ir_valid), 32'h0);
    check("ret_empty.stk_err", 32'(bus.stk_err), 32'h1);
`else
    cycle(mk_in(1, 1, 1, 8'h80, 1, 0, 0, 0));
    check("call.address", 32'(bus.address), 32'h80);
    check("call.ir_valid", 32'(bus.ir_valid), 32'h0);
    cycle(rdy);
    check("call.pc", 32'(bus.pc), 32'h80);
    cycle(mk_in(1, 1, 0, 8'h00, 0, 1, 0, 0));
    check("ret_ignored.pc", 32'(bus.pc), 32'h81);
    check("ret_ignored.ir_valid", 32'(bus.ir_valid), 32'h1);
    check("ret_ignored.address", 32'(bus.address), 32'h82);
    check("ret_ignored.stk_err", 32'(bus.stk_err), 32'h0);
`endif
    check_model("seq_end");

    // Randomized run against the model
    cycle(rst);
    for (int n = 0; n < 600; n++) begin
      ri.rst_n  = ($urandom_range(0, 99) != 0);
      ri.ready  = ($urandom_range(0, 3) != 0);
      ri.branch = ($urandom_range(0, 7) == 0);
      ri.baddr  = ($urandom_range(0, 1) == 0) ? addr_t'($urandom)
                                               : addr_t'($urandom_range(250, 255));
      ri.call   = ($urandom_range(0, 1) == 0);
      ri.ret    = ($urandom_range(0, 9) == 0);
      ri.halt   = ($urandom_range(0, 24) == 0);
      ri.resume = ($urandom_range(0, 3) == 0);
      cycle(ri);
      check_model($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
